// File: rtl/lab7_2_usb_gpo.sv
// Avalon-MM output port for USB control lines: level register with set/clear access
// plus a self-timed pulse that inverts masked bits for a programmable number of clocks.
module lab7_2_usb_gpo #(
  parameter int unsigned WIDTH         = 4,
  parameter logic [31:0] RESET_VALUE   = 32'h0,
  parameter int unsigned PULSE_W       = 16,
  parameter int unsigned PULSE_DEFAULT = 50
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] AddrData     = 3'd0;
  localparam logic [2:0] AddrPlen     = 3'd1;
  localparam logic [2:0] AddrPulse    = 3'd2;
  localparam logic [2:0] AddrStatus   = 3'd3;
  localparam logic [2:0] AddrOutset   = 3'd4;
  localparam logic [2:0] AddrOutclear = 3'd5;

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [PULSE_W-1:0] len_q, len_d;
  logic [PULSE_W-1:0] cnt_q, cnt_d;
  logic               overrun_q, overrun_d;
  logic [31:0]        readdata_q, readdata_d;

  logic             wr;
  logic             busy;
  logic [WIDTH-1:0] wmask;

  assign wr    = chipselect & ~write_n;
  assign busy  = (state_q == StActive);
  assign wmask = writedata[WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    mask_d    = mask_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;

    if (wr) begin
      case (address)
        AddrData:     data_d = wmask;
        AddrPlen:     len_d  = writedata[PULSE_W-1:0];
        AddrOutset:   data_d = data_q | wmask;
        AddrOutclear: data_d = data_q & ~wmask;
        AddrStatus:   if (writedata[1]) overrun_d = 1'b0;
        default:      ;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (wr && address == AddrPulse && len_q != '0 && wmask != '0) begin
          state_d = StActive;
          mask_d  = wmask;
          cnt_d   = len_q;
        end
      end
      StActive: begin
        cnt_d = cnt_q - PULSE_W'(1);
        if (cnt_q == PULSE_W'(1)) begin
          state_d = StIdle;
          mask_d  = '0;
        end
        // Retrigger while running is dropped; set overrides a same-edge W1C clear.
        if (wr && address == AddrPulse) overrun_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      AddrData:   readdata_d[WIDTH-1:0]   = data_q;
      AddrPlen:   readdata_d[PULSE_W-1:0] = len_q;
      AddrPulse:  readdata_d[WIDTH-1:0]   = busy ? mask_q : '0;
      AddrStatus: readdata_d[1:0]         = {overrun_q, busy};
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      data_q     <= RESET_VALUE[WIDTH-1:0];
      mask_q     <= '0;
      len_q      <= PULSE_W'(PULSE_DEFAULT);
      cnt_q      <= '0;
      overrun_q  <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      overrun_q  <= overrun_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = data_q ^ (busy ? mask_q : '0);

endmodule
